// File: rtl/aq_req_buf_pkg.sv
// Shared types for the LSU request buffer: entry state encoding and
// the back-off counter width.
package aq_req_buf_pkg;

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_PEND    = 2'd1,
    ST_ISSUED  = 2'd2,
    ST_BACKOFF = 2'd3
  } ent_st_e;

  localparam int BO_W = 4;

endpackage

// File: rtl/aq_req_buf_if.sv
// Request/arbiter/downstream/response bundle around aq_req_buf.
// slave = the buffer, master = the surrounding LSU/arbiter/downstream.
interface aq_req_buf_if #(
  parameter int NUM = 4,
  parameter int DW  = 40
);
  logic           in_vld;
  logic           in_rdy;
  logic [DW-1:0]  in_data;
  logic [NUM-1:0] arb_valid;
  logic [NUM-1:0] arb_sel;
  logic           arb_clr;
  logic           out_vld;
  logic           out_rdy;
  logic [DW-1:0]  out_data;
  logic [NUM-1:0] out_id;
  logic           resp_vld;
  logic [NUM-1:0] resp_id;
  logic           resp_retry;
  logic           flush;
  logic           full;
  logic           empty;

  modport slave (
    input  in_vld, in_data, arb_sel, out_rdy, resp_vld, resp_id, resp_retry, flush,
    output in_rdy, arb_valid, arb_clr, out_vld, out_data, out_id, full, empty
  );

  modport master (
    output in_vld, in_data, arb_sel, out_rdy, resp_vld, resp_id, resp_retry, flush,
    input  in_rdy, arb_valid, arb_clr, out_vld, out_data, out_id, full, empty
  );
endinterface

// File: rtl/aq_req_buf_entry.sv
// One buffer entry: state FSM, optional back-off counter, payload register.
// Back-off counter exists only with AQ_REQ_BUF_BACKOFF_EN defined.
module aq_req_buf_entry
  import aq_req_buf_pkg::*;
#(
  parameter int DW = 40
`ifdef AQ_REQ_BUF_BACKOFF_EN
  ,
  parameter int BO_CYC = 4
`endif
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          alloc,
  input  logic          issue,
  input  logic          resp_done,
  input  logic          resp_retry,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output ent_st_e       state,
  output logic [DW-1:0] data
);

`ifdef AQ_REQ_BUF_BACKOFF_EN
  logic [BO_W-1:0] cnt;
`endif

  // Entry FSM; an issue beats a coincident flush since downstream already took it.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= ST_FREE;
`ifdef AQ_REQ_BUF_BACKOFF_EN
      cnt   <= '0;
`endif
    end else if (issue) begin
      state <= ST_ISSUED;
    end else if (flush && (state == ST_PEND || state == ST_BACKOFF)) begin
      state <= ST_FREE;
`ifdef AQ_REQ_BUF_BACKOFF_EN
      cnt   <= '0;
`endif
    end else begin
      case (state)
        ST_FREE:   if (alloc) state <= ST_PEND;
        ST_ISSUED: begin
          if (resp_done) begin
            state <= ST_FREE;
          end else if (resp_retry) begin
`ifdef AQ_REQ_BUF_BACKOFF_EN
            state <= ST_BACKOFF;
            cnt   <= BO_W'(BO_CYC - 1);
`else
            state <= ST_PEND;
`endif
          end
        end
`ifdef AQ_REQ_BUF_BACKOFF_EN
        ST_BACKOFF: begin
          if (cnt == '0) state <= ST_PEND;
          else           cnt   <= cnt - 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  // Payload captured on allocation only; no reset needed.
  always_ff @(posedge clk) begin
    if (alloc) data <= din;
  end

endmodule

// File: rtl/aq_req_buf.sv
// LSU request buffer feeding an age-priority arbiter.
// Optional retry back-off: define AQ_REQ_BUF_BACKOFF_EN.
module aq_req_buf
  import aq_req_buf_pkg::*;
#(
  parameter int NUM    = 4,
  parameter int DW     = 40,
  parameter int BO_CYC = 4
) (
  input  logic         clk,
  input  logic         rst_b,
  aq_req_buf_if.slave  bus
);

  ent_st_e                st [NUM];
  logic [NUM-1:0][DW-1:0] dat;
  logic [NUM-1:0]         free_v, pend_v, iss_v;
  logic [NUM-1:0]         alloc_oh, grant, issue_v, rsp_hit, done_v, retry_v;
  logic                   in_rdy, out_vld, arb_clr;
  logic [DW-1:0]          out_data;

  // Lowest-index free entry takes the new request.
  assign in_rdy   = (|free_v) & ~bus.flush;
  assign alloc_oh = (bus.in_vld && in_rdy) ? (free_v & (~free_v + NUM'(1))) : '0;

  // Grant is qualified by PEND so a stray select never issues a non-pending entry.
  assign grant    = bus.arb_sel & pend_v;
  assign out_vld  = |grant;
  assign arb_clr  = out_vld & bus.out_rdy;
  assign issue_v  = grant & {NUM{arb_clr}};

  // Responses only land on entries that are actually ISSUED.
  assign rsp_hit  = bus.resp_vld ? (bus.resp_id & iss_v) : '0;
  assign done_v   = rsp_hit & {NUM{~bus.resp_retry}};
  assign retry_v  = rsp_hit & {NUM{bus.resp_retry}};

  // Downstream payload mux.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < NUM; i++)
      if (grant[i]) out_data = out_data | dat[i];
  end

  for (genvar i = 0; i < NUM; i++) begin : g_ent
    assign free_v[i] = (st[i] == ST_FREE);
    assign pend_v[i] = (st[i] == ST_PEND);
    assign iss_v[i]  = (st[i] == ST_ISSUED);

    aq_req_buf_entry #(
      .DW     (DW)
`ifdef AQ_REQ_BUF_BACKOFF_EN
      ,
      .BO_CYC (BO_CYC)
`endif
    ) u_ent (
      .clk        (clk),
      .rst_b      (rst_b),
      .alloc      (alloc_oh[i]),
      .issue      (issue_v[i]),
      .resp_done  (done_v[i]),
      .resp_retry (retry_v[i]),
      .flush      (bus.flush),
      .din        (bus.in_data),
      .state      (st[i]),
      .data       (dat[i])
    );
  end

  assign bus.in_rdy    = in_rdy;
  assign bus.arb_valid = pend_v;
  assign bus.arb_clr   = arb_clr;
  assign bus.out_vld   = out_vld;
  assign bus.out_data  = out_data;
  assign bus.out_id    = grant;
  assign bus.full      = ~|free_v;
  assign bus.empty     = &free_v;

  // Response id must be one-hot; back-off length must fit the counter.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      assert (!bus.resp_vld || $onehot(bus.resp_id))
        else $error("aq_req_buf: resp_id not one-hot");
      assert (BO_CYC >= 1 && BO_CYC <= 15)
        else $error("aq_req_buf: BO_CYC out of range");
    end
  end

endmodule

// File: tb/tb_aq_req_buf.sv
// Directed bench for aq_req_buf with an issue scoreboard.
module tb_aq_req_buf;
  localparam int NUM = 4;
  localparam int DW  = 40;
  localparam int BO  = 4;

  typedef struct packed {
    logic [NUM-1:0] id;
    logic [DW-1:0]  data;
  } sb_t;

  logic clk = 0;
  logic rst_b;
  aq_req_buf_if #(.NUM(NUM), .DW(DW)) bus ();

  aq_req_buf #(.NUM(NUM), .DW(DW), .BO_CYC(BO)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Simple arbiter model: lowest pending, or a forced select.
  logic           force_en;
  logic [NUM-1:0] force_val;
  always_comb begin
    bus.arb_sel = force_en ? force_val : (bus.arb_valid & (~bus.arb_valid + NUM'(1)));
  end

  int  checks = 0;
  int  errors = 0;
  sb_t sb [$];
  logic [DW-1:0] mdl [NUM];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [DW-1:0] d, input int idx);
    bus.in_vld  = 1'b1;
    bus.in_data = d;
    mdl[idx]    = d;
    tick();
    bus.in_vld  = 1'b0;
  endtask

  task automatic issue_one(input logic [NUM-1:0] id, input logic [DW-1:0] d, input string tag);
    sb_t e;
    force_en    = 1'b1;
    force_val   = id;
    bus.out_rdy = 1'b1;
    e.id = id; e.data = d;
    sb.push_back(e);
    #1;
    chk({tag, "_clr"}, 64'(bus.arb_clr), 64'd1);
    tick();
    bus.out_rdy = 1'b0;
    force_en    = 1'b0;
  endtask

  task automatic resp(input logic [NUM-1:0] id, input logic retry);
    bus.resp_vld   = 1'b1;
    bus.resp_id    = id;
    bus.resp_retry = retry;
    tick();
    bus.resp_vld   = 1'b0;
    bus.resp_retry = 1'b0;
  endtask

  // Scoreboard monitor: every downstream acceptance pops one expectation.
  always @(negedge clk) begin
    if (rst_b === 1'b1 && bus.arb_clr === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_issue", 64'(bus.out_id), 64'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("sb_out_id", 64'(bus.out_id), 64'(e.id));
        chk("sb_out_data", 64'(bus.out_data), 64'(e.data));
      end
    end
  end

  initial begin
    rst_b = 1'b0;
    force_en = 1'b0; force_val = '0;
    bus.in_vld = 0; bus.in_data = '0; bus.out_rdy = 0;
    bus.resp_vld = 0; bus.resp_id = '0; bus.resp_retry = 0; bus.flush = 0;
    #12;
    chk("rst_in_rdy",    64'(bus.in_rdy), 64'd1);
    chk("rst_arb_valid", 64'(bus.arb_valid), 64'd0);
    chk("rst_arb_clr",   64'(bus.arb_clr), 64'd0);
    chk("rst_out_vld",   64'(bus.out_vld), 64'd0);
    chk("rst_out_id",    64'(bus.out_id), 64'd0);
    chk("rst_full",      64'(bus.full), 64'd0);
    chk("rst_empty",     64'(bus.empty), 64'd1);
    @(negedge clk) rst_b = 1'b1;
    tick();

    // Single request through issue and done.
    alloc(40'h12, 0);
    #1;
    chk("t1_arb_valid", 64'(bus.arb_valid), 64'b0001);
    chk("t1_out_vld",   64'(bus.out_vld), 64'd1);
    chk("t1_out_data",  64'(bus.out_data), 64'h12);
    issue_one(4'b0001, 40'h12, "t1");
    chk("t1_clr_once",  64'(bus.arb_clr), 64'd0);
    chk("t1_issued_av", 64'(bus.arb_valid), 64'd0);
    chk("t1_not_empty", 64'(bus.empty), 64'd0);
    resp(4'b0001, 1'b0);
    chk("t1_empty", 64'(bus.empty), 64'd1);

    // Fill, reject fifth, free one, refill into freed slot.
    for (int i = 0; i < NUM; i++) alloc(40'hA0 + DW'(i), i);
    bus.in_vld = 1'b1; bus.in_data = 40'hFF;
    #1;
    chk("t2_full",   64'(bus.full), 64'd1);
    chk("t2_in_rdy", 64'(bus.in_rdy), 64'd0);
    tick();
    bus.in_vld = 1'b0;
    chk("t2_av_all", 64'(bus.arb_valid), 64'b1111);
    issue_one(4'b0010, mdl[1], "t2a");
    chk("t2_av_1iss", 64'(bus.arb_valid), 64'b1101);
    bus.resp_vld = 1'b1; bus.resp_id = 4'b0010; bus.resp_retry = 1'b0;
    #1;
    chk("t2_rdy_same_cyc", 64'(bus.in_rdy), 64'd0);
    tick();
    bus.resp_vld = 1'b0;
    chk("t2_rdy_next", 64'(bus.in_rdy), 64'd1);
    chk("t2_not_full", 64'(bus.full), 64'd0);
    alloc(40'hB1, 1);
    chk("t2_refill_av", 64'(bus.arb_valid), 64'b1111);
    issue_one(4'b0010, 40'hB1, "t2b");
    resp(4'b0010, 1'b0);

    // Retry timing.
    issue_one(4'b0001, mdl[0], "t3a");
    resp(4'b0001, 1'b1);
`ifdef AQ_REQ_BUF_BACKOFF_EN
    for (int k = 1; k <= BO; k++) begin
      chk($sformatf("t3_backoff_%0d", k), 64'(bus.arb_valid), 64'b1100);
      tick();
    end
`endif
    chk("t3_repend", 64'(bus.arb_valid), 64'b1101);

    // Flush with PEND (3), BACKOFF/PEND (0), ISSUED (2).
    issue_one(4'b0001, mdl[0], "t3b");
    issue_one(4'b0100, mdl[2], "t3c");
    resp(4'b0001, 1'b1);
    bus.flush = 1'b1; bus.in_vld = 1'b1; bus.in_data = 40'hCC;
    #1;
    chk("t4_flush_rdy", 64'(bus.in_rdy), 64'd0);
    tick();
    bus.flush = 1'b0; bus.in_vld = 1'b0;
    chk("t4_av_clear", 64'(bus.arb_valid), 64'd0);
    chk("t4_iss_kept", 64'(bus.empty), 64'd0);
    for (int k = 0; k < BO + 1; k++) tick();
    chk("t4_no_return", 64'(bus.arb_valid), 64'd0);
    resp(4'b0100, 1'b0);
    chk("t4_empty", 64'(bus.empty), 64'd1);

    // Flush coincident with issue of entry 2.
    for (int i = 0; i < NUM; i++) alloc(40'hD0 + DW'(i), i);
    force_en = 1'b1; force_val = 4'b0100; bus.out_rdy = 1'b1; bus.flush = 1'b1;
    sb.push_back(sb_t'{id: 4'b0100, data: mdl[2]});
    #1;
    chk("t5_rdy_flush", 64'(bus.in_rdy), 64'd0);
    chk("t5_clr",       64'(bus.arb_clr), 64'd1);
    tick();
    force_en = 1'b0; bus.out_rdy = 1'b0; bus.flush = 1'b0;
    chk("t5_av", 64'(bus.arb_valid), 64'd0);
    chk("t5_e2_issued", 64'(bus.empty), 64'd0);

    // Responses to PEND and FREE entries are ignored.
    alloc(40'hE0, 0);
    resp(4'b0001, 1'b0);
    chk("t6_pend_ign", 64'(bus.arb_valid), 64'b0001);
    resp(4'b0010, 1'b1);
    chk("t6_free_ign", 64'(bus.arb_valid), 64'b0001);
    alloc(40'hF1, 1);
    chk("t6_e1_free", 64'(bus.arb_valid), 64'b0011);
    issue_one(4'b0001, 40'hE0, "t6a");
    issue_one(4'b0010, 40'hF1, "t6b");
    resp(4'b0001, 1'b0);
    resp(4'b0010, 1'b0);
    resp(4'b0100, 1'b0);
    chk("t6_empty", 64'(bus.empty), 64'd1);

    // Asynchronous reset mid-operation.
    alloc(40'h77, 0);
    chk("t7_pre", 64'(bus.arb_valid), 64'b0001);
    #2 rst_b = 1'b0;
    #1;
    chk("t7_av",    64'(bus.arb_valid), 64'd0);
    chk("t7_empty", 64'(bus.empty), 64'd1);
    chk("t7_rdy",   64'(bus.in_rdy), 64'd1);
    tick();
    rst_b = 1'b1;
    tick();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
